aes_cipher_ctrl: RTL and testbench

// - Sequencer for the AES-128/256 encryption path. Starts the round-key generator, tracks when the

---
 rtl/aes_cipher_ctrl.sv | 138 +++++++++++++
 tb/tb_aes_cipher_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_ctrl.sv
// Sequencer for the AES-128/256 encryption path: key-expansion wait, round strobes, output handshake.
// Optional block counter enabled by defining AES_CTRL_PERF_EN.
module aes_cipher_ctrl #(
    parameter int KX_OVERHEAD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic        key_len_256,
    output logic        key_valid,
    output logic        key_err,
    output logic        kx_start,
    output logic [3:0]  kx_nk,
    output logic [3:0]  kx_addr,
    input  logic        blk_valid,
    output logic        blk_ready,
    output logic        dp_load,
    output logic        dp_round_en,
    output logic        dp_final,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] blk_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KX_WAIT,
        S_RUN,
        S_OUT
    } state_t;

    state_t      state, state_nxt;
    logic        len_256;
    logic [3:0]  round_ctr;
    logic [7:0]  wait_ctr;
    logic        key_valid_q;
    logic        kx_start_q;
    logic        key_accept;
    logic        kx_done;
    logic [3:0]  nr;
    logic [7:0]  wait_load;

    assign nr        = len_256 ? 4'd14 : 4'd10;
    assign wait_load = (key_len_256 ? 8'd14 : 8'd10) + 8'(KX_OVERHEAD);
    assign key_valid = key_valid_q;
    assign kx_start  = kx_start_q;
    assign kx_nk     = {1'b0, len_256, 2'b11};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        blk_ready   = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_final    = 1'b0;
        out_valid   = 1'b0;
        kx_addr     = 4'd0;
        key_err     = 1'b0;
        key_accept  = 1'b0;
        kx_done     = 1'b0;
        case (state)
            S_IDLE: begin
                blk_ready = key_valid_q & ~key_load;
                if (key_load) begin
                    key_accept = 1'b1;
                    state_nxt  = S_KX_WAIT;
                end else if (blk_valid && blk_ready) begin
                    dp_load   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_KX_WAIT: begin
                key_err = key_load;
                // Finishing on the step to zero makes key_valid rise Nr+KX_OVERHEAD cycles after kx_start.
                if (wait_ctr <= 8'd1) begin
                    kx_done   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                key_err     = key_load;
                dp_round_en = 1'b1;
                kx_addr     = round_ctr;
                dp_final    = (round_ctr == nr);
                if (dp_final) state_nxt = S_OUT;
            end
            S_OUT: begin
                key_err   = key_load;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_256     <= 1'b0;
            round_ctr   <= 4'd0;
            wait_ctr    <= 8'd0;
            key_valid_q <= 1'b0;
            kx_start_q  <= 1'b0;
        end else begin
            kx_start_q <= key_accept;
            if (key_accept) begin
                len_256     <= key_len_256;
                key_valid_q <= 1'b0;
                wait_ctr    <= wait_load;
            end else if (kx_done) begin
                key_valid_q <= 1'b1;
                wait_ctr    <= 8'd0;
            end else if (state == S_KX_WAIT) begin
                wait_ctr <= wait_ctr - 8'd1;
            end
            if (dp_load)       round_ctr <= 4'd1;
            else if (dp_final) round_ctr <= 4'd0;
            else if (dp_round_en) round_ctr <= round_ctr + 4'd1;
        end
    end

`ifdef AES_CTRL_PERF_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    blk_count_q <= 16'h0000;
        else if (out_valid && out_ready) blk_count_q <= blk_count_q + 16'h0001;
    end

    assign blk_count = blk_count_q;
`else
    assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Directed-plus-random bench for aes_cipher_ctrl; expected timing comes from a cycle-count model.
// Build with AES_CTRL_PERF_EN to also check the block counter.
module tb_aes_cipher_ctrl;

    logic        clk;
    logic        rst_n;
    logic        key_load;
    logic        key_len_256;
    logic        key_valid;
    logic        key_err;
    logic        kx_start;
    logic [3:0]  kx_nk;
    logic [3:0]  kx_addr;
    logic        blk_valid;
    logic        blk_ready;
    logic        dp_load;
    logic        dp_round_en;
    logic        dp_final;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] blk_count;

    int          total;
    int          bad;
    logic        kv_model;
    logic [3:0]  nk_model;
    logic [15:0] exp_blk;

    aes_cipher_ctrl #(.KX_OVERHEAD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_load    (key_load),
        .key_len_256 (key_len_256),
        .key_valid   (key_valid),
        .key_err     (key_err),
        .kx_start    (kx_start),
        .kx_nk       (kx_nk),
        .kx_addr     (kx_addr),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_final    (dp_final),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .blk_count   (blk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input logic e_load, input logic e_round, input logic e_final,
                                input logic e_ov, input logic e_ready, input logic e_start,
                                input logic e_err, input logic [3:0] e_addr);
        check("dp_load", 16'(dp_load), 16'(e_load));
        check("dp_round_en", 16'(dp_round_en), 16'(e_round));
        check("dp_final", 16'(dp_final), 16'(e_final));
        check("out_valid", 16'(out_valid), 16'(e_ov));
        check("blk_ready", 16'(blk_ready), 16'(e_ready));
        check("kx_start", 16'(kx_start), 16'(e_start));
        check("key_err", 16'(key_err), 16'(e_err));
        check("kx_addr", 16'(kx_addr), 16'(e_addr));
        check("key_valid", 16'(key_valid), 16'(kv_model));
        check("kx_nk", 16'(kx_nk), 16'(nk_model));
`ifdef AES_CTRL_PERF_EN
        check("blk_count", blk_count, exp_blk);
`else
        check("blk_count", blk_count, 16'h0000);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key load issued at cycle 0; kx_start at 1; key_valid at 1 + Nr + 4.
    task automatic load_key(input logic len, input logic with_blk, input int err_at);
        int nr;
        nr = len ? 14 : 10;
        tick();
        key_load = 1'b1;
        key_len_256 = len;
        blk_valid = with_blk;
        #1;
        check_output(0, 0, 0, 0, 0, 0, 0, 4'd0);
        kv_model = 1'b0;
        nk_model = len ? 4'h7 : 4'h3;
        for (int c = 1; c <= nr + 5; c++) begin
            tick();
            key_load = (c == err_at);
            key_len_256 = ~len;
            blk_valid = 1'b0;
            #1;
            if (c == nr + 5) kv_model = 1'b1;
            check_output(0, 0, 0, 0, kv_model, (c == 1), (c == err_at), 4'd0);
        end
        key_load = 1'b0;
    endtask

    task automatic run_block(input int delay, input int kl_round, input int rst_round);
        int nr;
        nr = (nk_model == 4'h7) ? 14 : 10;
        tick();
        blk_valid = 1'b1;
        #1;
        check_output(1, 0, 0, 0, 1, 0, 0, 4'd0);
        for (int r = 1; r <= nr; r++) begin
            tick();
            blk_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            key_load = (r == kl_round);
            #1;
            check_output(0, 1, (r == nr), 0, 0, 0, (r == kl_round), 4'(r));
            if (r == rst_round) begin
                rst_n = 1'b0;
                #1;
                kv_model = 1'b0;
                nk_model = 4'h3;
                exp_blk = 16'h0000;
                check_output(0, 0, 0, 0, 0, 0, (r == kl_round) ? 1'b0 : 1'b0, 4'd0);
                blk_valid = 1'b0;
                out_ready = 1'b0;
                key_load = 1'b0;
                tick();
                rst_n = 1'b1;
                return;
            end
        end
        key_load = 1'b0;
        for (int d = 0; d <= delay; d++) begin
            tick();
            blk_valid = 1'($urandom_range(0, 1));
            out_ready = (d == delay);
            #1;
            check_output(0, 0, 0, 1, 0, 0, 0, 4'd0);
        end
`ifdef AES_CTRL_PERF_EN
        exp_blk = exp_blk + 16'h0001;
`endif
        tick();
        out_ready = 1'b0;
        blk_valid = 1'b0;
        #1;
        check_output(0, 0, 0, 0, 1, 0, 0, 4'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        key_load = 1'b0;
        key_len_256 = 1'b0;
        blk_valid = 1'b0;
        out_ready = 1'b0;
        kv_model = 1'b0;
        nk_model = 4'h3;
        exp_blk = 16'h0000;
        #3;
        check_output(0, 0, 0, 0, 0, 0, 0, 4'd0);
        tick();
        rst_n = 1'b1;

        // Block offered with no key: stalls silently.
        for (int i = 0; i < 3; i++) begin
            tick();
            blk_valid = 1'b1;
            out_ready = 1'b1;
            #1;
            check_output(0, 0, 0, 0, 0, 0, 0, 4'd0);
        end
        blk_valid = 1'b0;
        out_ready = 1'b0;

        load_key(1'b0, 1'b0, 0);
        run_block(0, 0, 0);
        run_block(5, 3, 0);
        load_key(1'b1, 1'b1, 3);
        run_block(2, 0, 0);
        load_key(1'b0, 1'b0, 0);
        run_block(1, 0, 5);

        // After a mid-run reset the key must be reloaded before blocks are taken.
        for (int i = 0; i < 3; i++) begin
            tick();
            blk_valid = 1'b1;
            #1;
            check_output(0, 0, 0, 0, 0, 0, 0, 4'd0);
        end
        blk_valid = 1'b0;

        load_key(1'b0, 1'b0, 0);
        run_block(0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            load_key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)));
            run_block(int'($urandom_range(0, 6)), int'($urandom_range(0, 10)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
